// File: rtl/pc_pkg.sv
// Shared types and default widths for the fetch-stage program counter.
package pc_pkg;

    localparam int unsigned DEFAULT_D  = 8;
    localparam int unsigned DEFAULT_OW = 6;
    localparam int unsigned DEFAULT_SD = 4;

    typedef enum logic [2:0] {
        PC_HOLD,
        PC_INC,
        PC_JUMP,
        PC_BRANCH,
        PC_CALL,
        PC_RET
    } pc_src_e;

endpackage

// File: rtl/pc_stack_if.sv
// Control-decoder / instruction-memory side signals of the program counter.
interface pc_stack_if
    import pc_pkg::*;
#(
    parameter int unsigned D  = DEFAULT_D,
    parameter int unsigned OW = DEFAULT_OW,
    parameter int unsigned SD = DEFAULT_SD
);
    localparam int unsigned CW = $clog2(SD + 1);

    logic          stall;
    logic          jump_en;
    logic          branch_en;
    logic          call_en;
    logic          ret_en;
    logic [D-1:0]  target;
    logic [OW-1:0] offset;
    logic [D-1:0]  prog_ctr;
    logic [CW-1:0] stack_depth;
    logic          overflow;
    logic          underflow;

    modport master (
        output stall, jump_en, branch_en, call_en, ret_en, target, offset,
        input  prog_ctr, stack_depth, overflow, underflow
    );

    modport slave (
        input  stall, jump_en, branch_en, call_en, ret_en, target, offset,
        output prog_ctr, stack_depth, overflow, underflow
    );

endinterface

// File: rtl/ret_stack.sv
// LIFO return-address stack; push is ignored when full, pop when empty.
module ret_stack #(
    parameter int unsigned DW = 8,
    parameter int unsigned SD = 4,
    localparam int unsigned CW = $clog2(SD + 1),
    localparam int unsigned AW = (SD > 1) ? $clog2(SD) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_push_data,
    output logic [DW-1:0] o_top,
    output logic [CW-1:0] o_depth,
    output logic          o_full,
    output logic          o_empty
);

    logic [DW-1:0] r_mem [SD];
    logic [CW-1:0] r_depth;
    logic [CW-1:0] w_depth_m1;
    logic [AW-1:0] w_wr_idx;
    logic [AW-1:0] w_top_idx;

    assign w_depth_m1 = r_depth - CW'(1);
    assign w_wr_idx   = w_wr_idx_f(r_depth);
    assign w_top_idx  = w_wr_idx_f(w_depth_m1);
    assign o_full     = (r_depth == CW'(SD));
    assign o_empty    = (r_depth == '0);
    assign o_depth    = r_depth;
    assign o_top      = r_mem[w_top_idx];

    function automatic logic [AW-1:0] w_wr_idx_f(input logic [CW-1:0] d);
        return AW'(d);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            r_depth <= '0;
        end else if (i_push && !o_full) begin
            r_depth <= r_depth + CW'(1);
        end else if (i_pop && !o_empty) begin
            r_depth <= w_depth_m1;
        end
    end

    // Entry contents need no reset; only depth defines validity.
    always_ff @(posedge clk) begin
        if (!reset && i_push && !o_full) begin
            r_mem[w_wr_idx] <= i_push_data;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Fetch-stage program counter with relative branches, call/return stack and stall.
module pc_stack
    import pc_pkg::*;
#(
    parameter int unsigned D  = DEFAULT_D,
    parameter int unsigned OW = DEFAULT_OW,
    parameter int unsigned SD = DEFAULT_SD
) (
    input  logic       clk,
    input  logic       reset,
    pc_stack_if.slave  bus
);

    localparam int unsigned CW = $clog2(SD + 1);

    pc_src_e       w_src;
    logic [D-1:0]  r_pc;
    logic [D-1:0]  w_pc_next;
    logic [D-1:0]  w_inc;
    logic [D-1:0]  w_off_ext;
    logic [D-1:0]  w_top;
    logic [CW-1:0] w_depth;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          r_overflow;
    logic          r_underflow;

    always_comb begin
        w_src = PC_INC;
        if (bus.stall) begin
            w_src = PC_HOLD;
        end else if (bus.ret_en) begin
            w_src = PC_RET;
        end else if (bus.call_en) begin
            w_src = PC_CALL;
        end else if (bus.jump_en) begin
            w_src = PC_JUMP;
        end else if (bus.branch_en) begin
            w_src = PC_BRANCH;
        end
    end

    assign w_inc     = r_pc + D'(1);
    assign w_off_ext = D'($signed(bus.offset));
    assign w_push    = (w_src == PC_CALL);
    assign w_pop     = (w_src == PC_RET);

    always_comb begin
        w_pc_next = r_pc;
        unique case (w_src)
            PC_HOLD:          w_pc_next = r_pc;
            PC_INC:           w_pc_next = w_inc;
            PC_JUMP, PC_CALL: w_pc_next = bus.target;
            PC_BRANCH:        w_pc_next = r_pc + w_off_ext;
            // A return with nothing to pop falls through to the next instruction.
            PC_RET:           w_pc_next = w_empty ? w_inc : w_top;
            default:          w_pc_next = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_pc        <= w_pc_next;
            r_overflow  <= r_overflow | (w_push & w_full);
            r_underflow <= r_underflow | (w_pop & w_empty);
        end
    end

    ret_stack #(
        .DW (D),
        .SD (SD)
    ) u_ret_stack (
        .clk         (clk),
        .reset       (reset),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_push_data (w_inc),
        .o_top       (w_top),
        .o_depth     (w_depth),
        .o_full      (w_full),
        .o_empty     (w_empty)
    );

    assign bus.prog_ctr    = r_pc;
    assign bus.stack_depth = w_depth;
    assign bus.overflow    = r_overflow;
    assign bus.underflow   = r_underflow;

endmodule

// File: tb/tb_pc_stack.sv
// Randomised and directed checks of pc_stack against a queue-based reference model.
module tb_pc_stack;

    localparam int unsigned D  = 8;
    localparam int unsigned OW = 6;
    localparam int unsigned SD = 4;

    logic clk;
    logic reset;

    pc_stack_if #(.D(D), .OW(OW), .SD(SD)) bus ();

    pc_stack #(.D(D), .OW(OW), .SD(SD)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // Reference model state
    int m_pc;
    int m_stack[$];
    bit m_ovf;
    bit m_unf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_step(input bit rst, st, rt, cl, jp, br,
                                       input int tg, input int of);
        int so;
        so = (of >= 32) ? of - 64 : of;
        if (rst) begin
            m_pc = 0;
            m_stack.delete();
            m_ovf = 0;
            m_unf = 0;
        end else if (st) begin
            // frozen
        end else if (rt) begin
            if (m_stack.size() > 0) begin
                m_pc = m_stack.pop_back();
            end else begin
                m_pc  = (m_pc + 1) % 256;
                m_unf = 1;
            end
        end else if (cl) begin
            if (m_stack.size() < SD) m_stack.push_back((m_pc + 1) % 256);
            else m_ovf = 1;
            m_pc = tg;
        end else if (jp) begin
            m_pc = tg;
        end else if (br) begin
            m_pc = (m_pc + so + 256) % 256;
        end else begin
            m_pc = (m_pc + 1) % 256;
        end
    endfunction

    task automatic drive(input bit rst, st, rt, cl, jp, br,
                         input logic [7:0] tg, input logic [5:0] of);
        reset         = rst;
        bus.stall     = st;
        bus.ret_en    = rt;
        bus.call_en   = cl;
        bus.jump_en   = jp;
        bus.branch_en = br;
        bus.target    = tg;
        bus.offset    = of;
        @(posedge clk);
        model_step(rst, st, rt, cl, jp, br, int'(tg), int'(of));
        #1;
        check("prog_ctr", 32'(bus.prog_ctr), 32'(m_pc));
        check("stack_depth", 32'(bus.stack_depth), 32'(m_stack.size()));
        check("overflow", 32'(bus.overflow), 32'(m_ovf));
        check("underflow", 32'(bus.underflow), 32'(m_unf));
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 8'h00, 6'h00);
    endtask

    initial begin
        m_pc = 0;
        m_ovf = 0;
        m_unf = 0;
        reset = 1'b1;
        bus.stall = 0; bus.ret_en = 0; bus.call_en = 0;
        bus.jump_en = 0; bus.branch_en = 0;
        bus.target = '0; bus.offset = '0;

        // Reset, then free-running increments
        drive(1, 0, 0, 0, 0, 0, 8'h00, 6'h00);
        check("reset_pc", 32'(bus.prog_ctr), 32'h0);
        for (int i = 1; i <= 3; i++) begin
            idle();
            check("seq_pc", 32'(bus.prog_ctr), 32'(i));
        end

        // Wrap from all-ones
        drive(0, 0, 0, 0, 1, 0, 8'hFE, 6'h00);
        idle();
        check("wrap_ff", 32'(bus.prog_ctr), 32'hFF);
        idle();
        check("wrap_00", 32'(bus.prog_ctr), 32'h00);

        // Negative branches, including wrap below zero
        drive(0, 0, 0, 0, 1, 0, 8'h10, 6'h00);
        drive(0, 0, 0, 0, 0, 1, 8'h00, 6'b111100);
        check("branch_neg", 32'(bus.prog_ctr), 32'h0C);
        drive(0, 0, 0, 0, 1, 0, 8'h02, 6'h00);
        drive(0, 0, 0, 0, 0, 1, 8'h00, 6'b111100);
        check("branch_wrap", 32'(bus.prog_ctr), 32'hFE);

        // Call then return
        drive(0, 0, 0, 0, 1, 0, 8'h20, 6'h00);
        drive(0, 0, 0, 1, 0, 0, 8'h80, 6'h00);
        check("call_pc", 32'(bus.prog_ctr), 32'h80);
        check("call_depth", 32'(bus.stack_depth), 32'd1);
        repeat (3) idle();
        drive(0, 0, 1, 0, 0, 0, 8'h00, 6'h00);
        check("ret_pc", 32'(bus.prog_ctr), 32'h21);
        check("ret_depth", 32'(bus.stack_depth), 32'd0);

        // Overflow past SD, LIFO unwind, then underflow
        for (int i = 0; i < 5; i++) drive(0, 0, 0, 1, 0, 0, 8'(8'h90 + 8'(i * 4)), 6'h00);
        check("ovf_depth", 32'(bus.stack_depth), 32'(SD));
        check("ovf_flag", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0, 0, 0, 8'h00, 6'h00);
        check("unf_flag", 32'(bus.underflow), 32'd1);
        repeat (3) idle();
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Stall drops enables
        drive(0, 0, 0, 0, 1, 0, 8'h40, 6'h00);
        drive(0, 1, 0, 1, 1, 0, 8'h99, 6'h00);
        check("stall_pc", 32'(bus.prog_ctr), 32'h40);
        idle();
        check("unstall_pc", 32'(bus.prog_ctr), 32'h41);

        // Call outranks jump and branch; reset outranks ret
        drive(1, 0, 0, 0, 0, 0, 8'h00, 6'h00);
        drive(0, 0, 0, 1, 1, 1, 8'h55, 6'h05);
        check("prio_call", 32'(bus.prog_ctr), 32'h55);
        drive(0, 0, 0, 1, 0, 0, 8'h66, 6'h00);
        drive(0, 0, 1, 0, 0, 0, 8'h00, 6'h00);
        drive(1, 0, 1, 0, 0, 0, 8'h00, 6'h00);
        check("rst_ret_pc", 32'(bus.prog_ctr), 32'h0);
        check("rst_ret_depth", 32'(bus.stack_depth), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(59) == 0,
                  $urandom_range(7) == 0,
                  $urandom_range(4) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(3) == 0,
                  $urandom_range(2) == 0,
                  8'($urandom), 6'($urandom));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Next-generation program counter for the 141L core's fetch stage.
- Fully parametrised in address width, relative-offset width and return-stack depth.
- Adds signed PC-relative branches, subroutine call/return through an internal LIFO return-address stack, and fetch stall on top of absolute jumps.
- Sits between the control decoder (enables, target, offset) and instruction memory (prog_ctr).

Parameters:
- D, 8: program counter / address width in bits.
- OW, 6: width of the signed two's-complement relative branch offset.
- SD, 4: return-address stack depth in entries. Must be ≥ 1.
- Derived, not overridable: CW = $clog2(SD+1), the width of stack_depth.

Ports:
- clk  input  1  Rising-edge clock.
- reset  input  1  Synchronous, active-high reset.
- stall  input  1  Freeze PC and stack this cycle.
- jump_en  input  1  Absolute jump to target.
- branch_en  input  1  Relative branch by offset.
- call_en  input  1  Push return address, then jump to target.
- ret_en  input  1  Pop the return stack into the PC.
- target  input  D  Absolute jump/call address.
- offset  input  OW  Signed relative branch displacement.
- prog_ctr  output  D  Current instruction address (registered).
- stack_depth  output  CW  Number of valid stack entries (registered).
- overflow  output  1  Sticky: a call occurred with the stack full.
- underflow  output  1  Sticky: a return occurred with the stack empty.

Behaviour:
- One clock (clk); reset is synchronous and active-high. All state updates on the rising edge of clk.
- Reset values: prog_ctr = 0, stack_depth = 0, overflow = 0, underflow = 0. Stack entry contents are don't-care.
- Reset has priority over every other input, including stall and simultaneous enables.
- Priority when several controls are high in one cycle: reset > stall > ret_en > call_en > jump_en > branch_en > sequential increment. Lower-priority enables are ignored for that cycle.
- stall: prog_ctr, the stack and the flags hold their values. Enables asserted during a stall are dropped, not queued.
- Sequential: prog_ctr <= prog_ctr + 1, modulo 2^D. All-ones wraps to 0.
- jump_en: prog_ctr <= target.
- branch_en: prog_ctr <= prog_ctr + sign_extend(offset), modulo 2^D. Wrap in either direction is legal and unflagged.
- call_en with stack_depth < SD:
  - Push (prog_ctr + 1) mod 2^D.
  - stack_depth increments.
  - prog_ctr <= target.
- call_en with stack_depth == SD:
  - prog_ctr <= target.
  - Push suppressed; existing entries preserved.
  - overflow <= 1.
- ret_en with stack_depth > 0:
  - prog_ctr <= top entry.
  - stack_depth decrements.
- ret_en with stack_depth == 0:
  - prog_ctr <= prog_ctr + 1.
  - underflow <= 1.
- Latency: every effect is visible on prog_ctr and stack_depth exactly one cycle after the enabling edge. No combinational path from any input to any output.
- overflow and underflow are sticky and are cleared only by reset.
- Stack is strict LIFO; a pop always returns the most recent successful push.

Decomposition:
- Shared package pc_pkg:
  - Enum of next-PC sources: PC_HOLD, PC_INC, PC_JUMP, PC_BRANCH, PC_CALL, PC_RET.
  - Default width constants.
- One sub-module, ret_stack: parametrised LIFO with push, pop, push_data, top, depth, full, empty.
  - Push and pop are never asserted together.
  - full/empty are combinational from depth.
- The top level holds a priority encoder that selects the pc_pkg source, plus the next-PC mux and the sticky flags.

Test Plan:
- Reset then 3 free-running cycles -> prog_ctr 0,1,2,3. D=8 run from 0xFE -> 0xFF then 0x00.
- prog_ctr=0x10, branch_en, offset=6'b111100 (-4) -> 0x0C. prog_ctr=0x02, offset=-4 -> 0xFE (wrap).
- prog_ctr=0x20, call_en, target=0x80 -> prog_ctr 0x80, depth 1. Three cycles later ret_en -> prog_ctr 0x21, depth 0.
- Five calls with SD=4 -> depth saturates at 4 and overflow=1. Four rets return addresses in reverse push order. A fifth ret -> PC increments, underflow=1. Both flags stay 1 until reset.
- prog_ctr=0x40, stall with call_en and jump_en high -> prog_ctr 0x40, depth unchanged. Release stall -> 0x41.
- call_en, jump_en and branch_en together -> call wins. reset asserted together with ret_en mid-stack -> prog_ctr 0, depth 0, flags 0.
